// File: rtl/ccff_shifter_if.sv
// Block handshake between the AES datapath (master) and the configuration-chain
// shifter (slave).
interface ccff_shifter_if #(
  parameter int BLK_W = 128
) ();
  logic             blk_valid_i;
  logic [BLK_W-1:0] blk_data_i;
  logic             blk_ready_o;

  modport master (output blk_valid_i, output blk_data_i, input  blk_ready_o);
  modport slave  (input  blk_valid_i, input  blk_data_i, output blk_ready_o);
endinterface

// File: rtl/ccff_shifter.sv
// Serialises decrypted bitstream blocks onto the fabric configuration chain, MSB first,
// one bit per two clocks. Define CCFF_TAIL_CHECK_EN to enable the chain-tail ones monitor.
module ccff_shifter #(
  parameter int BLK_W         = 128,
  parameter int CNT_W         = 16,
  parameter int PRESET_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] bit_count_i,
  input  logic             abort_i,
  ccff_shifter_if.slave    blk,
  output logic             data_o,
  output logic             progclk_o,
  output logic             pReset_o,
  input  logic             ccff_tail_i,
  output logic [CNT_W-1:0] tail_ones_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);
  localparam int IDX_W = $clog2(BLK_W + 1);
  localparam int PRE_W = (PRESET_CYCLES > 1) ? $clog2(PRESET_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PRESET, S_WAIT_BLK, S_SHIFT_LO, S_SHIFT_HI, S_DONE
  } state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_remaining;
  logic [IDX_W-1:0] r_bit_idx;
  logic [BLK_W-1:0] r_shreg;
  logic [PRE_W-1:0] r_pre_cnt;
  logic             r_data;
  logic             r_err;

  logic             w_start, w_abort;
  logic [CNT_W-1:0] w_rem_dec;
  logic [IDX_W-1:0] w_idx_dec;

  assign w_start   = (r_state == S_IDLE) && start_i;
  assign w_abort   = (r_state != S_IDLE) && abort_i;
  assign w_rem_dec = r_remaining - 1'b1;
  assign w_idx_dec = r_bit_idx - 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Abort outranks everything, including a block transfer in the same cycle.
  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (start_i) w_next = S_PRESET;
        S_PRESET:   if (r_pre_cnt == PRE_W'(PRESET_CYCLES - 1))
                      w_next = (r_remaining != '0) ? S_WAIT_BLK : S_DONE;
        S_WAIT_BLK: if (blk.blk_valid_i) w_next = S_SHIFT_LO;
        S_SHIFT_LO: w_next = S_SHIFT_HI;
        S_SHIFT_HI: begin
          if (w_rem_dec == '0)      w_next = S_DONE;
          else if (w_idx_dec == '0) w_next = S_WAIT_BLK;
          else                      w_next = S_SHIFT_LO;
        end
        S_DONE:     w_next = S_IDLE;
        default:    w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_remaining <= '0;
      r_bit_idx   <= '0;
      r_shreg     <= '0;
      r_pre_cnt   <= '0;
      r_data      <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_start) begin
      r_remaining <= bit_count_i;
      r_pre_cnt   <= '0;
      r_err       <= 1'b0;
    end else if (w_abort) begin
      r_err       <= 1'b1;
    end else begin
      case (r_state)
        S_PRESET:   r_pre_cnt <= r_pre_cnt + 1'b1;
        S_WAIT_BLK: if (blk.blk_valid_i) begin
          r_shreg   <= blk.blk_data_i;
          r_bit_idx <= IDX_W'(BLK_W);
        end
        S_SHIFT_LO: r_data <= r_shreg[BLK_W-1];
        S_SHIFT_HI: begin
          r_shreg     <= {r_shreg[BLK_W-2:0], 1'b0};
          r_remaining <= w_rem_dec;
          r_bit_idx   <= w_idx_dec;
        end
        default: ;
      endcase
    end
  end

  // data_o is valid for the whole SHIFT_LO cycle and held through SHIFT_HI, so the
  // fabric sees a full clk of setup before progclk_o rises.
  assign data_o          = (r_state == S_SHIFT_LO) ? r_shreg[BLK_W-1] : r_data;
  assign progclk_o       = (r_state == S_SHIFT_HI);
  assign pReset_o        = (r_state == S_PRESET);
  assign blk.blk_ready_o = (r_state == S_WAIT_BLK);
  assign busy_o          = (r_state == S_PRESET) || (r_state == S_WAIT_BLK) ||
                           (r_state == S_SHIFT_LO) || (r_state == S_SHIFT_HI);
  assign done_o          = (r_state == S_DONE);
  assign err_o           = r_err;

`ifdef CCFF_TAIL_CHECK_EN
  logic [CNT_W-1:0] r_tail_ones;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_tail_ones <= '0;
    else if (w_start)
      r_tail_ones <= '0;
    else if ((r_state == S_SHIFT_HI) && ccff_tail_i && (r_tail_ones != '1))
      r_tail_ones <= r_tail_ones + 1'b1;
  end

  assign tail_ones_o = r_tail_ones;
`else
  logic w_unused_tail;
  assign w_unused_tail = ccff_tail_i;
  assign tail_ones_o   = '0;
`endif

endmodule

// File: tb/tb_ccff_shifter.sv
// Directed + randomized bench for ccff_shifter; expected chain stream, timing and
// counters come from a block-level model of the session.
module tb_ccff_shifter;
  localparam int BLK_W = 128;
  localparam int CNT_W = 16;
  localparam int PRE_C = 4;

  logic             clk_i = 1'b0;
  logic             rst_i, start_i, abort_i, tail_val;
  logic [CNT_W-1:0] bit_count_i;
  logic             data_o, progclk_o, pReset_o, busy_o, done_o, err_o;
  logic [CNT_W-1:0] tail_ones_o;

  ccff_shifter_if #(.BLK_W(BLK_W)) bif ();

  ccff_shifter #(.BLK_W(BLK_W), .CNT_W(CNT_W), .PRESET_CYCLES(PRE_C)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .bit_count_i (bit_count_i),
    .abort_i     (abort_i),
    .blk         (bif),
    .data_o      (data_o),
    .progclk_o   (progclk_o),
    .pReset_o    (pReset_o),
    .ccff_tail_i (tail_val),
    .tail_ones_o (tail_ones_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0, miscompares = 0;
  int rises = 0, dones = 0, done_busy = 0, presets = 0, readies = 0, xfers = 0;
  logic prev_pclk = 1'b0;
  bit   bits_q[$];
  logic [BLK_W-1:0] blks [5];

  // Chain-side observer: every progclk_o rise is one bit captured by the fabric.
  always @(negedge clk_i) begin
    if (progclk_o && !prev_pclk) begin
      rises++;
      bits_q.push_back(data_o);
    end
    prev_pclk = progclk_o;
    if (done_o) dones++;
    if (done_o && busy_o) done_busy++;
    if (pReset_o) presets++;
    if (bif.blk_ready_o) readies++;
    if (bif.blk_ready_o && bif.blk_valid_i && !abort_i) xfers++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_blocks();
    for (int b = 0; b < 5; b++)
      for (int w = 0; w < BLK_W / 32; w++)
        blks[b][w*32 +: 32] = $urandom;
  endtask

  // One configuration session of n bits; abort_bit >= 0 aborts once that many bits went out.
  task automatic session(input int n, input int abort_bit, input logic tv);
    int nb, r0, d0, x0, p0, rd0, q0, k, done_k, bi, exp_bits, exp_blk, exp_tail;
    bit aborted, finished, poked, xfer;
    logic [511:0] obs, expv;
    nb = (n + BLK_W - 1) / BLK_W;
    tail_val = tv;
    r0 = rises; d0 = dones; x0 = xfers; p0 = presets; rd0 = readies; q0 = bits_q.size();
    @(posedge clk_i); #1;
    start_i = 1'b1; bit_count_i = CNT_W'(n);
    @(posedge clk_i); #1;
    start_i = 1'b0; bit_count_i = CNT_W'($urandom);
    check("busy_after_start", int'(busy_o), 1);
    check("err_cleared_by_start", int'(err_o), 0);
    k = 0; done_k = -1; bi = 0; aborted = 0; finished = 0; poked = 0;
    while (k < 3000) begin
      if (aborted) begin
        abort_i = 1'b0;
        check("abort_err", int'(err_o), 1);
        check("abort_busy", int'(busy_o), 0);
        check("abort_progclk", int'(progclk_o), 0);
        check("abort_done", int'(done_o), 0);
        finished = 1;
        break;
      end
      if (done_o) begin
        done_k = k; finished = 1;
        check("done_busy_low", int'(busy_o), 0);
        break;
      end
      bif.blk_valid_i = 1'b1;
      bif.blk_data_i  = blks[bi];
      if (abort_bit >= 0 && rises - r0 == abort_bit) begin
        abort_i = 1'b1; aborted = 1;
      end else if (!poked && n > 20 && rises - r0 == 10) begin
        start_i = 1'b1; bit_count_i = CNT_W'(3); poked = 1;
      end
      xfer = bif.blk_ready_o && bif.blk_valid_i && !abort_i;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      k++;
      if (xfer) bi++;
    end
    repeat (8) begin
      bif.blk_valid_i = 1'b1; bif.blk_data_i = blks[4];
      @(posedge clk_i); #1;
    end
    bif.blk_valid_i = 1'b0;
    @(negedge clk_i); #1;

    exp_bits = (abort_bit >= 0) ? abort_bit : n;
    exp_blk  = (exp_bits + BLK_W - 1) / BLK_W;
`ifdef CCFF_TAIL_CHECK_EN
    exp_tail = tv ? exp_bits : 0;
`else
    exp_tail = 0;
`endif
    obs = '0; expv = '0;
    for (int i = 0; i < exp_bits; i++) begin
      expv[i] = blks[i / BLK_W][BLK_W - 1 - (i % BLK_W)];
      obs[i]  = (q0 + i < bits_q.size()) ? bits_q[q0 + i] : 1'bx;
    end
    check("session_finished", int'(finished), 1);
    check("progclk_rises", rises - r0, exp_bits);
    check_vec("chain_stream", obs, expv);
    check("done_pulses", dones - d0, (abort_bit >= 0) ? 0 : 1);
    check("blocks_accepted", xfers - x0, exp_blk);
    check("preset_cycles", presets - p0, PRE_C);
    check("tail_ones", int'(tail_ones_o), exp_tail);
    check("err_final", int'(err_o), (abort_bit >= 0) ? 1 : 0);
    check("done_with_busy", done_busy, 0);
    if (abort_bit < 0) begin
      check("done_latency", done_k, PRE_C + nb + 2 * n);
      check("ready_cycles", readies - rd0, nb);
    end
  endtask

  initial begin
    int k, r0;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; tail_val = 1'b0;
    bit_count_i = '0; bif.blk_valid_i = 1'b0; bif.blk_data_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", int'(bif.blk_ready_o), 0);
    check("rst_data", int'(data_o), 0);
    check("rst_progclk", int'(progclk_o), 0);
    check("rst_preset", int'(pReset_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_err", int'(err_o), 0);
    check("rst_tail", int'(tail_ones_o), 0);
    rst_i = 1'b0;

    // abort while idle is a no-op
    @(posedge clk_i); #1 abort_i = 1'b1;
    @(posedge clk_i); #1 abort_i = 1'b0;
    @(posedge clk_i); #1;
    check("idle_abort_err", int'(err_o), 0);
    check("idle_abort_busy", int'(busy_o), 0);

    blks[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    blks[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
    blks[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
    blks[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;
    blks[4] = 128'hdeadbeefcafef00d0123456789abcdef;
    session(256, -1, 1'b1);
    rand_blocks(); session(200, -1, 1'b0);
    rand_blocks(); session(0, -1, 1'b1);
    rand_blocks(); session(128, 50, 1'b1);
    rand_blocks(); session(128, -1, 1'b1);
    rand_blocks(); session(200, 128, 1'b0);
    rand_blocks(); session(1, -1, 1'b1);
    rand_blocks(); session(129, -1, 1'b0);
    for (int s = 0; s < 4; s++) begin
      rand_blocks();
      session(int'($urandom_range(1, 384)), -1, 1'($urandom_range(0, 1)));
    end
    rand_blocks(); session(300, int'($urandom_range(1, 299)), 1'b1);

    // asynchronous reset in the middle of a SHIFT_HI cycle
    rand_blocks();
    tail_val = 1'b1;
    r0 = rises;
    @(posedge clk_i); #1 start_i = 1'b1; bit_count_i = CNT_W'(128);
    @(posedge clk_i); #1 start_i = 1'b0;
    bif.blk_valid_i = 1'b1; bif.blk_data_i = blks[0];
    k = 0;
    while (k < 400 && !(progclk_o && rises - r0 >= 20)) begin
      @(posedge clk_i); #1;
      k++;
    end
    check("reach_shift_hi", int'(progclk_o), 1);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_progclk", int'(progclk_o), 0);
    check("async_rst_data", int'(data_o), 0);
    check("async_rst_busy", int'(busy_o), 0);
    check("async_rst_ready", int'(bif.blk_ready_o), 0);
    check("async_rst_preset", int'(pReset_o), 0);
    check("async_rst_done", int'(done_o), 0);
    check("async_rst_err", int'(err_o), 0);
    check("async_rst_tail", int'(tail_ones_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0; bif.blk_valid_i = 1'b0;
    rand_blocks(); session(5, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
